ising_energy_engine: RTL and testbench

Streaming engine that computes the Ising-style quadratic energy E = σᵀ·J·σ for one spin vector σ against an N×N coupling matrix J. J arrives as column chunks over a valid/ready stream, and σ is captured once per run. This generation replaces the free-running chunk counter with a handshaked input, a signed/unsigned J mode, a pipelined accumulate, abort, and a threshold flag. It sits between the J-memory streamer and the annealing controller.

---
 rtl/ising_energy_if.sv | 31 +++
 rtl/ising_energy_engine.sv | 172 +++++++++++++++++
 tb/tb_ising_energy_engine.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ising_energy_if.sv
// Handshake bundle between the J-memory streamer / annealing controller and the
// Ising energy engine: run control, sigma capture, J chunk stream and results.
interface ising_energy_if #(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int J_COLS_PER_CLK  = 4,
  parameter int ENERGY_WIDTH    = 2*$clog2(VECTOR_SIZE)+J_ELEMENT_WIDTH+1
);
  logic                                              start;
  logic                                              abort;
  logic [VECTOR_SIZE-1:0]                            sigma;
  logic signed [ENERGY_WIDTH-1:0]                    energy_threshold;
  logic                                              j_valid;
  logic                                              j_ready;
  logic [VECTOR_SIZE*J_COLS_PER_CLK*J_ELEMENT_WIDTH-1:0] j_chunk;
  logic                                              busy;
  logic                                              done;
  logic                                              aborted;
  logic signed [ENERGY_WIDTH-1:0]                    energy_out;
  logic                                              above_threshold;

  modport master (
    output start, abort, sigma, energy_threshold, j_valid, j_chunk,
    input  j_ready, busy, done, aborted, energy_out, above_threshold
  );

  modport slave (
    input  start, abort, sigma, energy_threshold, j_valid, j_chunk,
    output j_ready, busy, done, aborted, energy_out, above_threshold
  );
endinterface

// File: rtl/ising_energy_engine.sv
// Streaming E = sigma^T * J * sigma: one column chunk of J per handshake, a
// registered block sum per chunk, and a one-stage accumulate behind it.

// Signed dot product of one J column against the +/-1 spin vector.
module ising_col_dot #(
  parameter int N        = 256,
  parameter int JW       = 4,
  parameter int J_SIGNED = 0,
  parameter int DW       = $clog2(N)+JW+1
) (
  input  logic [N-1:0]          sigma,
  input  logic [N-1:0][JW-1:0]  col_j,
  output logic signed [DW-1:0]  dot
);
  logic signed [DW-1:0] e;

  always_comb begin
    dot = '0;
    e   = '0;
    for (int r = 0; r < N; r++) begin
      if (J_SIGNED != 0) e = DW'($signed(col_j[r]));
      else               e = DW'(col_j[r]);
      dot = sigma[r] ? dot + e : dot - e;
    end
  end
endmodule

module ising_energy_engine #(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int J_COLS_PER_CLK  = 4,
  parameter int J_SIGNED        = 0,
  parameter int ENERGY_WIDTH    = 2*$clog2(VECTOR_SIZE)+J_ELEMENT_WIDTH+1
) (
  input  logic         clk,
  input  logic         rst_n,
  ising_energy_if.slave bus
);
  localparam int N          = VECTOR_SIZE;
  localparam int JW         = J_ELEMENT_WIDTH;
  localparam int C          = J_COLS_PER_CLK;
  localparam int EW         = ENERGY_WIDTH;
  localparam int NUM_CHUNKS = N / C;
  localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int SW         = $clog2(N);
  localparam int DW         = $clog2(N)+JW+1;
  localparam int BW         = DW + $clog2(C);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]             state;
  logic [N-1:0]           sigma_q;
  logic [CW-1:0]          chunk_cnt;
  logic signed [BW-1:0]   block_q;
  logic                   block_v;
  logic signed [EW-1:0]   acc_q;
  logic signed [EW-1:0]   acc_next;
  logic                   done_q;
  logic                   aborted_q;
  logic                   above_q;

  logic                   j_ready;
  logic                   hs;
  logic                   last_chunk;
  logic [SW-1:0]          col_base;
  logic [N-1:0]           sig_sh;
  logic [C-1:0]           sig_cols;
  logic signed [BW-1:0]   block_sum;
  logic signed [BW-1:0]   dext;

  logic [C-1:0][N-1:0][JW-1:0] col_j;
  logic signed [DW-1:0]        dot [C];

  // Abort masks ready so a chunk offered alongside it is never consumed.
  assign j_ready    = (state == S_RUN) && !bus.abort;
  assign hs         = j_ready && bus.j_valid;
  assign last_chunk = (chunk_cnt == CW'(NUM_CHUNKS-1));

  genvar gc, gr;
  generate
    for (gc = 0; gc < C; gc++) begin : g_col
      for (gr = 0; gr < N; gr++) begin : g_row
        assign col_j[gc][gr] = bus.j_chunk[(gr*C+gc)*JW +: JW];
      end
      ising_col_dot #(.N(N), .JW(JW), .J_SIGNED(J_SIGNED), .DW(DW)) u_col (
        .sigma (sigma_q),
        .col_j (col_j[gc]),
        .dot   (dot[gc])
      );
    end
  endgenerate

  // Outer spins for this chunk's global columns chunk_cnt*C .. chunk_cnt*C+C-1.
  assign col_base = SW'(chunk_cnt) * SW'(C);
  assign sig_sh   = sigma_q >> col_base;
  assign sig_cols = sig_sh[C-1:0];

  always_comb begin
    block_sum = '0;
    dext      = '0;
    for (int c = 0; c < C; c++) begin
      dext      = BW'(dot[c]);
      block_sum = sig_cols[c] ? block_sum + dext : block_sum - dext;
    end
  end

  assign acc_next = acc_q + EW'(block_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sigma_q   <= '0;
      chunk_cnt <= '0;
      block_q   <= '0;
      block_v   <= 1'b0;
      acc_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      above_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        state     <= S_IDLE;
        aborted_q <= 1'b1;
        acc_q     <= '0;
        block_v   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state     <= S_RUN;
              sigma_q   <= bus.sigma;
              chunk_cnt <= '0;
              acc_q     <= '0;
              block_v   <= 1'b0;
            end
          end
          S_RUN: begin
            if (block_v) acc_q <= acc_next;
            block_v <= hs;
            if (hs) begin
              block_q   <= block_sum;
              chunk_cnt <= chunk_cnt + CW'(1);
              if (last_chunk) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            // Only the final block is in flight here; fold it in and finish.
            if (block_v) begin
              acc_q   <= acc_next;
              block_v <= 1'b0;
              done_q  <= 1'b1;
              above_q <= (acc_next >= bus.energy_threshold);
              state   <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.j_ready         = j_ready;
  assign bus.busy            = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done            = done_q;
  assign bus.aborted         = aborted_q;
  assign bus.energy_out      = acc_q;
  assign bus.above_threshold = above_q;
endmodule

// File: tb/tb_ising_energy_engine.sv
// Directed bench: an unsigned-J and a signed-J engine driven by identical stimulus,
// checked against hand values and a direct double-sum energy model.
module tb_ising_energy_engine;
  localparam int N  = 8;
  localparam int C  = 2;
  localparam int JW = 4;
  localparam int EW = 11;
  localparam int NC = N / C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [N-1:0]         sigma = '0;
  logic signed [EW-1:0] thr_u = '0;
  logic signed [EW-1:0] thr_s = '0;
  logic                 j_valid = 1'b0;
  logic [N*C*JW-1:0]    j_chunk = '0;

  ising_energy_if #(.VECTOR_SIZE(N), .J_ELEMENT_WIDTH(JW), .J_COLS_PER_CLK(C), .ENERGY_WIDTH(EW)) if_u ();
  ising_energy_if #(.VECTOR_SIZE(N), .J_ELEMENT_WIDTH(JW), .J_COLS_PER_CLK(C), .ENERGY_WIDTH(EW)) if_s ();

  assign if_u.start = start;  assign if_s.start = start;
  assign if_u.abort = abort;  assign if_s.abort = abort;
  assign if_u.sigma = sigma;  assign if_s.sigma = sigma;
  assign if_u.energy_threshold = thr_u;
  assign if_s.energy_threshold = thr_s;
  assign if_u.j_valid = j_valid;  assign if_s.j_valid = j_valid;
  assign if_u.j_chunk = j_chunk;  assign if_s.j_chunk = j_chunk;

  ising_energy_engine #(.VECTOR_SIZE(N), .J_ELEMENT_WIDTH(JW), .J_COLS_PER_CLK(C),
                        .J_SIGNED(0), .ENERGY_WIDTH(EW)) u_dut (
    .clk (clk), .rst_n (rst_n), .bus (if_u)
  );
  ising_energy_engine #(.VECTOR_SIZE(N), .J_ELEMENT_WIDTH(JW), .J_COLS_PER_CLK(C),
                        .J_SIGNED(1), .ENERGY_WIDTH(EW)) u_dut_s (
    .clk (clk), .rst_n (rst_n), .bus (if_s)
  );

  logic [JW-1:0] jm [N][N];
  int total = 0;
  int bad   = 0;
  int exp_above_u = 0;
  int exp_above_s = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [N*C*JW-1:0] mk_chunk(input int k);
    logic [N*C*JW-1:0] ch;
    ch = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < C; c++)
        ch[(r*C+c)*JW +: JW] = jm[r][k*C+c];
    return ch;
  endfunction

  // E = sum_r sum_c s_r * J[r][c] * s_c with s = +1 for bit 1, -1 for bit 0.
  function automatic int model(input logic [N-1:0] sg, input bit sgn);
    int e;
    int j;
    e = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        j = sgn ? int'($signed(jm[r][c])) : int'(jm[r][c]);
        e += (sg[r] == sg[c]) ? j : -j;
      end
    return e;
  endfunction

  task automatic fill_const(input logic [JW-1:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) jm[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) jm[r][c] = JW'($urandom_range(0, 15));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_j_ready"}, int'(if_u.j_ready), 0);
    chk({tag, "_busy"},    int'(if_u.busy), 0);
    chk({tag, "_done"},    int'(if_u.done), 0);
    chk({tag, "_aborted"}, int'(if_u.aborted), 0);
    chk({tag, "_energy"},  int'(if_u.energy_out), 0);
    chk({tag, "_above"},   int'(if_u.above_threshold), 0);
    chk({tag, "_above_s"}, int'(if_s.above_threshold), 0);
  endtask

  // Full run; stall bit i drops j_valid on the i-th RUN cycle. Called right at a
  // done cycle this also exercises back-to-back start acceptance.
  task automatic run(input string tag, input logic [N-1:0] sg, input int tu, input int ts,
                     input logic [15:0] stall, input bit mid_start);
    int  k, idx, lat, nst, eu, es;
    bit  hs;
    eu = model(sg, 1'b0);
    es = model(sg, 1'b1);
    sigma = sg;
    thr_u = EW'(tu);
    thr_s = EW'(ts);
    j_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(if_u.busy), 1);
    chk({tag, "_acc_cleared"}, int'(if_u.energy_out), 0);
    chk({tag, "_done_one_cycle"}, int'(if_u.done), 0);
    k = 0; idx = 0; lat = 0; nst = 0;
    while (k < NC && idx < 40) begin
      j_chunk = mk_chunk(k);
      j_valid = (idx < 16) ? !stall[idx] : 1'b1;
      start   = mid_start && (idx == 1);
      if (!j_valid) nst++;
      hs = j_valid && if_u.j_ready;
      @(negedge clk);
      lat++; idx++;
      if (hs) k++;
    end
    j_valid = 1'b0;
    start   = 1'b0;
    chk({tag, "_drain_ready_low"}, int'(if_u.j_ready), 0);
    chk({tag, "_drain_busy"}, int'(if_u.busy), 1);
    while (!if_u.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, NC + 1 + nst);
    chk({tag, "_done_s"}, int'(if_s.done), 1);
    chk({tag, "_energy_u"}, int'(if_u.energy_out), eu);
    chk({tag, "_energy_s"}, int'(if_s.energy_out), es);
    exp_above_u = (eu >= tu) ? 1 : 0;
    exp_above_s = (es >= ts) ? 1 : 0;
    chk({tag, "_above_u"}, int'(if_u.above_threshold), exp_above_u);
    chk({tag, "_above_s"}, int'(if_s.above_threshold), exp_above_s);
  endtask

  initial begin
    fill_const(4'h1);
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Hand values: all-ones J gives (sum s)^2.
    run("ones_ff", 8'hFF, 64, 64, 16'h0000, 1'b0);
    run("ones_00", 8'h00, 65, 64, 16'h0000, 1'b0);
    run("ones_55", 8'h55, 1, 1, 16'h0000, 1'b0);

    // 4'hF: 15 unsigned -> 960, -1 signed -> -64.
    fill_const(4'hF);
    run("allf_ff", 8'hFF, 961, -64, 16'h0000, 1'b0);
    chk("allf_hand_u", int'(if_u.energy_out), 960);
    chk("allf_hand_s", int'(if_s.energy_out), -64);

    fill_rand();
    run("rand_a", 8'hC9, 0, 0, 16'b0110_1001_1010_0101, 1'b0);
    fill_rand();
    run("rand_b", 8'h3A, -1000, -1000, 16'b1001_0110_0101_1010, 1'b1);
    @(negedge clk);
    chk("done_cleared", int'(if_u.done), 0);

    // Abort after chunk 2, with a stray start in the middle of the run.
    fill_rand();
    sigma = 8'hA7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      j_chunk = mk_chunk(i);
      j_valid = 1'b1;
      start   = (i == 1);
      @(negedge clk);
    end
    start   = 1'b0;
    j_chunk = mk_chunk(3);
    j_valid = 1'b1;
    abort   = 1'b1;
    #1;
    chk("abort_ready_masked", int'(if_u.j_ready), 0);
    @(negedge clk);
    abort   = 1'b0;
    j_valid = 1'b0;
    chk("abort_pulse_u", int'(if_u.aborted), 1);
    chk("abort_pulse_s", int'(if_s.aborted), 1);
    chk("abort_busy", int'(if_u.busy), 0);
    chk("abort_no_done", int'(if_u.done), 0);
    chk("abort_energy", int'(if_u.energy_out), 0);
    chk("abort_above_kept_u", int'(if_u.above_threshold), exp_above_u);
    chk("abort_above_kept_s", int'(if_s.above_threshold), exp_above_s);
    @(negedge clk);
    chk("abort_one_cycle", int'(if_u.aborted), 0);
    chk("abort_still_no_done", int'(if_u.done), 0);

    // Reset in the middle of a run.
    sigma = 8'h5E;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      j_chunk = mk_chunk(i);
      j_valid = 1'b1;
      @(negedge clk);
    end
    j_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    run("after_reset", 8'h5E, 50, -50, 16'b0000_0000_0000_0100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
